// File: rtl/filt_reg_arbiter.sv
// filt_reg_arbiter: round-robin arbiter that serialises register reads and
// writes from NREQ requesters onto the filter's single register-access bus.
// Every output is driven straight from a flop; no path from req_i reaches
// an output without passing through a register.
module filt_reg_arbiter #(
  parameter int NREQ   = 3,
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0]          req_wr_i,
  input  logic [NREQ*AWIDTH-1:0]   req_addr_i,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata_i,
  output logic [NREQ-1:0]          ack_o,
  output logic [DWIDTH-1:0]        rsp_rdata_o,
  output logic                     busy_o,
  output logic                     acc_en_o,
  output logic                     wr_en_o,
  output logic [AWIDTH-1:0]        addr_o,
  output logic [DWIDTH-1:0]        wdata_o,
  input  logic [DWIDTH-1:0]        rdata_i
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RWAIT  = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDXW-1:0]     last_q, last_d;
  logic [IDXW-1:0]     win_q, win_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [DWIDTH-1:0]   rsp_q, rsp_d;
  logic                busy_q, busy_d;
  logic                acc_en_q, acc_en_d;
  logic                wr_en_q, wr_en_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;

  logic                grant_valid_s;
  logic [IDXW-1:0]     grant_idx_s;
  logic [IDXW-1:0]     cand_idx_s;
  logic                hit_s;

  // Round-robin search: first requesting index above the last winner, wrapping.
  always_comb begin : arb_search
    int cand;
    cand          = 0;
    cand_idx_s    = '0;
    hit_s         = 1'b0;
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand          = int'(last_q) + 1 + i;
      cand          = (cand >= NREQ) ? (cand - NREQ) : cand;
      cand_idx_s    = IDXW'(cand);
      hit_s         = !grant_valid_s && req_i[cand_idx_s];
      grant_idx_s   = hit_s ? cand_idx_s : grant_idx_s;
      grant_valid_s = grant_valid_s | hit_s;
    end
  end

  // Next-state and next-output logic; bus strobes default low every cycle.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    rsp_d    = rsp_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    acc_en_d = 1'b0;
    wr_en_d  = 1'b0;
    ack_d    = '0;
    busy_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          // Latch the winner's access straight into the bus output flops.
          state_d  = ACCESS;
          win_d    = grant_idx_s;
          last_d   = grant_idx_s;
          acc_en_d = 1'b1;
          wr_en_d  = req_wr_i[grant_idx_s];
          addr_d   = req_addr_i[grant_idx_s*AWIDTH +: AWIDTH];
          wdata_d  = req_wdata_i[grant_idx_s*DWIDTH +: DWIDTH];
        end else begin
          state_d  = IDLE;
        end
      end
      ACCESS: begin
        // wr_en_q still holds the latched direction during the strobe cycle.
        state_d = wr_en_q ? DONE : RWAIT;
      end
      RWAIT: begin
        rsp_d   = rdata_i;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ack_d[win_q] = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  // State and registered-output flops; reset parks the pointer so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      last_q   <= IDXW'(NREQ - 1);
      win_q    <= '0;
      ack_q    <= '0;
      rsp_q    <= '0;
      busy_q   <= 1'b0;
      acc_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      ack_q    <= ack_d;
      rsp_q    <= rsp_d;
      busy_q   <= busy_d;
      acc_en_q <= acc_en_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign ack_o       = ack_q;
  assign rsp_rdata_o = rsp_q;
  assign busy_o      = busy_q;
  assign acc_en_o    = acc_en_q;
  assign wr_en_o     = wr_en_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;

endmodule

// File: tb/tb_filt_reg_arbiter.sv
// Scoreboard bench for filt_reg_arbiter: stimulus pushes expected bus
// accesses and acks into queues, monitors pop and compare at negedges.
module tb_filt_reg_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [2:0]  req_wr = 3'b000;
  logic [23:0] req_addr = 24'h0;
  logic [47:0] req_wdata = 48'h0;
  logic [2:0]  ack;
  logic [15:0] rsp;
  logic        busy;
  logic        acc_en;
  logic        wr_en;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata = 16'h0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } bus_t;

  typedef struct {
    logic [2:0]  ack;
    logic [15:0] rsp;
  } ack_t;

  bus_t bus_q[$];
  ack_t ack_q[$];

  filt_reg_arbiter #(.NREQ(3), .AWIDTH(8), .DWIDTH(16)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_i       (req),
    .req_wr_i    (req_wr),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .ack_o       (ack),
    .rsp_rdata_o (rsp),
    .busy_o      (busy),
    .acc_en_o    (acc_en),
    .wr_en_o     (wr_en),
    .addr_o      (addr),
    .wdata_o     (wdata),
    .rdata_i     (rdata)
  );

  always #5 clk = ~clk;

  // Register-bus model: read data appears the cycle after a read strobe.
  always @(posedge clk) begin
    if (acc_en && !wr_en)
      rdata <= (addr == 8'h10) ? 16'h1234 : {addr, ~addr};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input int k, input logic wr, input logic [7:0] a, input logic [15:0] d);
    req_wr[k]             = wr;
    req_addr[k*8 +: 8]    = a;
    req_wdata[k*16 +: 16] = d;
    req[k]                = 1'b1;
  endtask

  task automatic exp_txn(input int k, input logic wr, input logic [7:0] a,
                         input logic [15:0] d, input logic [15:0] r);
    bus_t b;
    ack_t x;
    b.wr = wr; b.addr = a; b.wdata = d;
    x.ack = 3'b000;
    x.ack[k] = 1'b1;
    x.rsp = r;
    bus_q.push_back(b);
    ack_q.push_back(x);
  endtask

  // Wait for n acks (bounded); requesters not in hold drop req at their ack.
  task automatic wait_acks(input int n, input logic [2:0] hold);
    int cnt;
    cnt = 0;
    for (int c = 0; c < 200 && cnt < n; c++) begin
      @(negedge clk);
      if (ack != 3'b000) begin
        cnt++;
        for (int k = 0; k < 3; k++)
          if (ack[k] && !hold[k]) req[k] = 1'b0;
      end
    end
    if (cnt < n) chk("ack_timeout", cnt, n);
  endtask

  // Monitor: compare every bus strobe and every ack against the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      chk("wr_en_outside_access", {31'd0, wr_en & ~acc_en}, 32'd0);
      if (acc_en) begin
        if (bus_q.size() == 0) begin
          chk("bus_unexpected_access", {24'd0, addr}, 32'hFFFF_FFFF);
        end else begin
          bus_t b;
          b = bus_q.pop_front();
          chk("bus_wr", {31'd0, wr_en}, {31'd0, b.wr});
          chk("bus_addr", {24'd0, addr}, {24'd0, b.addr});
          chk("bus_wdata", {16'd0, wdata}, {16'd0, b.wdata});
        end
      end
      if (ack != 3'b000) begin
        chk("ack_onehot", {31'd0, $onehot(ack)}, 32'd1);
        if (ack_q.size() == 0) begin
          chk("ack_unexpected", {29'd0, ack}, 32'hFFFF_FFFF);
        end else begin
          ack_t x;
          x = ack_q.pop_front();
          chk("ack_vec", {29'd0, ack}, {29'd0, x.ack});
          chk("ack_rsp", {16'd0, rsp}, {16'd0, x.rsp});
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, {29'd0, ack}, 32'd0);
    chk({tag, "_acc_en"}, {31'd0, acc_en}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_addr"}, {24'd0, addr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, wdata}, 32'd0);
    chk({tag, "_rsp"}, {16'd0, rsp}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Single write by requester 0 with cycle-exact latency checks
    issue(0, 1'b1, 8'h05, 16'hA5A5);
    exp_txn(0, 1'b1, 8'h05, 16'hA5A5, 16'h0000);
    @(negedge clk);
    chk("w_acc_en_t1", {31'd0, acc_en}, 32'd1);
    chk("w_wr_en_t1", {31'd0, wr_en}, 32'd1);
    chk("w_addr_t1", {24'd0, addr}, 32'h05);
    chk("w_wdata_t1", {16'd0, wdata}, 32'hA5A5);
    chk("w_busy_t1", {31'd0, busy}, 32'd1);
    chk("w_ack_t1", {29'd0, ack}, 32'd0);
    @(negedge clk);
    chk("w_ack_t2", {29'd0, ack}, 32'd1);
    chk("w_acc_en_t2", {31'd0, acc_en}, 32'd0);
    chk("w_busy_t2", {31'd0, busy}, 32'd1);
    req[0] = 1'b0;
    @(negedge clk);
    chk("w_busy_t3", {31'd0, busy}, 32'd0);
    chk("w_ack_t3", {29'd0, ack}, 32'd0);

    // Single read by requester 2 of addr 0x10 (bus returns 0x1234)
    issue(2, 1'b0, 8'h10, 16'h0000);
    exp_txn(2, 1'b0, 8'h10, 16'h0000, 16'h1234);
    @(negedge clk);
    chk("r_acc_en_t1", {31'd0, acc_en}, 32'd1);
    chk("r_wr_en_t1", {31'd0, wr_en}, 32'd0);
    chk("r_addr_t1", {24'd0, addr}, 32'h10);
    @(negedge clk);
    chk("r_acc_en_t2", {31'd0, acc_en}, 32'd0);
    chk("r_ack_t2", {29'd0, ack}, 32'd0);
    chk("r_busy_t2", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("r_ack_t3", {29'd0, ack}, 32'h4);
    chk("r_rsp_t3", {16'd0, rsp}, 32'h1234);
    req[2] = 1'b0;
    // A later write leaves the read data untouched
    issue(0, 1'b1, 8'h20, 16'h5555);
    exp_txn(0, 1'b1, 8'h20, 16'h5555, 16'h1234);
    wait_acks(1, 3'b000);
    @(negedge clk);
    chk("rsp_hold_after_write", {16'd0, rsp}, 32'h1234);

    // Contention: all three request from reset, served 0,1,2,0,1,2
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) issue(k, 1'b1, 8'(8'h40 + k), 16'(16'h1000 + k));
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 3; k++) exp_txn(k, 1'b1, 8'(8'h40 + k), 16'(16'h1000 + k), 16'h0000);
    repeat (2) @(negedge clk);
    chk_all_zero("reset2");
    rstn = 1'b1;
    wait_acks(6, 3'b111);
    req = 3'b000;
    repeat (3) @(negedge clk);

    // Fairness: requester 0 continuous, requester 1 once -> 0,1,0
    issue(0, 1'b1, 8'h50, 16'h2222);
    exp_txn(0, 1'b1, 8'h50, 16'h2222, 16'h0000);
    @(negedge clk);
    issue(1, 1'b1, 8'h51, 16'h3333);
    exp_txn(1, 1'b1, 8'h51, 16'h3333, 16'h0000);
    exp_txn(0, 1'b1, 8'h50, 16'h2222, 16'h0000);
    wait_acks(3, 3'b001);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Withdrawn request: requester 1 drops req and changes addr during ACCESS
    issue(1, 1'b1, 8'h30, 16'hBEEF);
    exp_txn(1, 1'b1, 8'h30, 16'hBEEF, 16'h0000);
    @(negedge clk);
    req[1] = 1'b0;
    req_addr[15:8] = 8'hFF;
    wait_acks(1, 3'b000);
    repeat (6) @(negedge clk);

    // Reset during RWAIT: requester 2 served last, then read aborted
    issue(2, 1'b1, 8'h60, 16'h6666);
    exp_txn(2, 1'b1, 8'h60, 16'h6666, 16'h0000);
    wait_acks(1, 3'b000);
    @(negedge clk);
    issue(2, 1'b0, 8'h10, 16'h0000);
    begin
      bus_t b;
      b.wr = 1'b0; b.addr = 8'h10; b.wdata = 16'h0000;
      bus_q.push_back(b);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_all_zero("rwait_reset");
    issue(0, 1'b1, 8'h70, 16'h7777);
    exp_txn(0, 1'b1, 8'h70, 16'h7777, 16'h0000);
    exp_txn(2, 1'b0, 8'h10, 16'h0000, 16'h1234);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_acks(2, 3'b000);
    repeat (4) @(negedge clk);

    chk("bus_q_drained", bus_q.size(), 32'd0);
    chk("ack_q_drained", ack_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
